// File: rtl/eth_tx_arbiter_if.sv
// Stream bundle between the frame generators, the TX arbiter and the 10G MAC.
// Source lanes are packed flat: source i occupies data [64i+63:64i], keep [8i+7:8i].
interface eth_tx_arbiter_if #(
    parameter int unsigned N_SRC = 3
);
    logic [N_SRC-1:0]    src_req;
    logic [N_SRC-1:0]    src_grant;
    logic [N_SRC-1:0]    src_tready;
    logic [64*N_SRC-1:0] s_tdata;
    logic [8*N_SRC-1:0]  s_tkeep;
    logic [N_SRC-1:0]    s_tvalid;
    logic [N_SRC-1:0]    s_tlast;

    logic [63:0]         m_axis_tdata;
    logic [7:0]          m_axis_tkeep;
    logic                m_axis_tvalid;
    logic                m_axis_tlast;
    logic                m_axis_tuser;
    logic                m_axis_tready;

    // Arbiter side
    modport slave (
        input  src_req, s_tdata, s_tkeep, s_tvalid, s_tlast, m_axis_tready,
        output src_grant, src_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    // Generator / MAC side
    modport master (
        output src_req, s_tdata, s_tkeep, s_tvalid, s_tlast, m_axis_tready,
        input  src_grant, src_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the MAC TX stream between N_SRC generators,
// with post-frame idle gap and a stall watchdog that closes hung frames with an abort beat.
module eth_tx_arbiter #(
    parameter int unsigned N_SRC      = 3,
    parameter int unsigned IFG_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        aclk,
    input  logic        areset,
    eth_tx_arbiter_if.slave axis,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] frame_count,
    output logic [7:0]  abort_count
);
    localparam int unsigned IW       = $clog2(N_SRC);
    localparam int unsigned WW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GW       = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, XFER, ABORT, GAP} state_t;
    localparam state_t POST_FRAME = (IFG_CYCLES > 0) ? GAP : IDLE;

    state_t          state;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   last_grant;
    logic [N_SRC-1:0] grant_oh;
    logic [WW-1:0]   wdog;
    logic [GW-1:0]   gap_cnt;

    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cidx;
    logic            found;
    int unsigned     c;

    logic [63:0]     m_tdata;
    logic [7:0]      m_tkeep;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tuser;
    logic [N_SRC-1:0] s_ready;
    logic            accept;

    // Search upward from last_grant+1 with wrap; last_grant itself comes last.
    always_comb begin
        pick_idx = '0;
        cidx     = '0;
        found    = 1'b0;
        c        = 0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            c = 32'(last_grant) + k;
            if (c >= N_SRC) c = c - N_SRC;
            cidx = IW'(c);
            if (!found && axis.src_req[cidx]) begin
                found    = 1'b1;
                pick_idx = cidx;
            end
        end
    end

    always_comb begin
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tuser  = 1'b0;
        s_ready  = '0;
        case (state)
            XFER: begin
                for (int unsigned i = 0; i < N_SRC; i++) begin
                    if (grant_idx == IW'(i)) begin
                        m_tdata    = axis.s_tdata[64*i +: 64];
                        m_tkeep    = axis.s_tkeep[8*i +: 8];
                        m_tvalid   = axis.s_tvalid[i];
                        m_tlast    = axis.s_tlast[i];
                        s_ready[i] = axis.m_axis_tready;
                    end
                end
            end
            ABORT: begin
                m_tvalid = 1'b1;
                m_tlast  = 1'b1;
                m_tuser  = 1'b1;
                m_tkeep  = 8'h01;
            end
            default: ;
        endcase
    end

    assign accept = (state == XFER) && m_tvalid && axis.m_axis_tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= IDLE;
            grant_idx   <= '0;
            last_grant  <= IW'(N_SRC - 1);
            grant_oh    <= '0;
            wdog        <= '0;
            gap_cnt     <= '0;
            frame_count <= '0;
            abort_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant_idx  <= pick_idx;
                        last_grant <= pick_idx;
                        grant_oh   <= N_SRC'(1) << pick_idx;
                        wdog       <= '0;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        wdog <= '0;
                        if (m_tlast) begin
                            frame_count <= frame_count + 16'd1;
                            grant_oh    <= '0;
                            gap_cnt     <= '0;
                            state       <= POST_FRAME;
                        end
                    end else if (wdog == WW'(TIMEOUT - 1)) begin
                        grant_oh    <= '0;
                        timeout_err <= 1'b1;
                        if (abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
                        state       <= ABORT;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                ABORT: begin
                    if (axis.m_axis_tready) begin
                        gap_cnt <= '0;
                        state   <= POST_FRAME;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_LAST)) state <= IDLE;
                    else gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy               = (state != IDLE);
    assign axis.src_grant     = grant_oh;
    assign axis.src_tready    = s_ready;
    assign axis.m_axis_tdata  = m_tdata;
    assign axis.m_axis_tkeep  = m_tkeep;
    assign axis.m_axis_tvalid = m_tvalid;
    assign axis.m_axis_tlast  = m_tlast;
    assign axis.m_axis_tuser  = m_tuser;
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: a 3-source build with a 2-cycle gap and
// a second build with no gap, driven from one initial block of scenario tasks.
module tb_eth_tx_arbiter;
    logic        aclk = 1'b0;
    logic        areset;
    logic        busy, timeout_err, busy0, timeout_err0;
    logic [15:0] frame_count, frame_count0;
    logic [7:0]  abort_count, abort_count0;

    int checks = 0;
    int errors = 0;
    int tmo_pulses = 0;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;
    beat_t mac_q[$];

    eth_tx_arbiter_if #(.N_SRC(3)) bus ();
    eth_tx_arbiter_if #(.N_SRC(3)) bus0 ();

    eth_tx_arbiter #(.N_SRC(3), .IFG_CYCLES(2), .TIMEOUT(64)) dut (
        .aclk(aclk), .areset(areset), .axis(bus.slave), .busy(busy),
        .timeout_err(timeout_err), .frame_count(frame_count), .abort_count(abort_count)
    );

    eth_tx_arbiter #(.N_SRC(3), .IFG_CYCLES(0), .TIMEOUT(64)) dut0 (
        .aclk(aclk), .areset(areset), .axis(bus0.slave), .busy(busy0),
        .timeout_err(timeout_err0), .frame_count(frame_count0), .abort_count(abort_count0)
    );

    always #5 aclk = ~aclk;

    // Beats the MAC will take at the coming rising edge.
    always @(negedge aclk) begin
        if (!areset && bus.m_axis_tvalid && bus.m_axis_tready)
            mac_q.push_back({bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tuser});
        if (!areset && timeout_err) tmo_pulses++;
    end

    function automatic logic [63:0] beat_data(input int s, input int fr, input int b);
        return {s[7:0], fr[7:0], b[15:0], 16'hC0DE, b[15:0]};
    endfunction

    task automatic apply_reset();
        areset = 1'b1;
        bus.src_req = '0; bus.s_tvalid = '0; bus.s_tlast = '0;
        bus.s_tdata = '0; bus.s_tkeep = '0; bus.m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    // Called and returns at posedge+1.
    task automatic wait_grant(output logic [2:0] g);
        int n;
        g = '0;
        n = 0;
        while (g == '0 && n < 50) begin
            @(negedge aclk);
            g = bus.src_grant;
            n++;
        end
        if (g == '0) begin
            checks++; errors++;
            $display("FAIL grant_wait: got %b, expected a grant within 50 cycles", g);
        end
        @(posedge aclk); #1;
    endtask

    // Drives nb beats on source s; called and returns at posedge+1.
    task automatic send_frame(input int s, input int nb, input logic [7:0] lk, input int fr, input bit term);
        bit acc;
        int n;
        for (int b = 0; b < nb; b++) begin
            bus.s_tdata[64*s +: 64] = beat_data(s, fr, b);
            bus.s_tkeep[8*s +: 8]   = (b == nb - 1) ? lk : 8'hFF;
            bus.s_tvalid[s]         = 1'b1;
            bus.s_tlast[s]          = term && (b == nb - 1);
            acc = 1'b0;
            n = 0;
            while (!acc && n < 200) begin
                @(negedge aclk);
                acc = bus.src_tready[s];
                @(posedge aclk); #1;
                n++;
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL beat_accept: src %0d beat %0d got no tready, expected accept within 200 cycles", s, b);
                bus.s_tvalid[s] = 1'b0;
                return;
            end
        end
        bus.s_tvalid[s] = 1'b0;
        bus.s_tlast[s]  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge aclk);
        checks++;
        if (bus.src_grant !== 3'b000 || bus.src_tready !== 3'b000) begin
            errors++;
            $display("FAIL reset_grant: got grant=%b tready=%b, expected 000/000", bus.src_grant, bus.src_tready);
        end
        checks++;
        if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tkeep, bus.m_axis_tdata} !== 75'd0) begin
            errors++;
            $display("FAIL reset_mac: got v=%b l=%b u=%b k=%h d=%h, expected all 0", bus.m_axis_tvalid,
                     bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tkeep, bus.m_axis_tdata);
        end
        checks++;
        if ({busy, timeout_err, frame_count, abort_count} !== 26'd0) begin
            errors++;
            $display("FAIL reset_status: got busy=%b tmo=%b fc=%0d ac=%0d, expected 0/0/0/0",
                     busy, timeout_err, frame_count, abort_count);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_single_frame();
        logic [2:0] g;
        int idle;
        beat_t exp;
        mac_q.delete();
        bus.src_req = 3'b010;
        @(negedge aclk);
        checks++;
        if (bus.src_grant !== 3'b000) begin
            errors++;
            $display("FAIL grant_latency_early: got %b, expected 000", bus.src_grant);
        end
        @(posedge aclk); #1;
        @(negedge aclk);
        checks++;
        if (bus.src_grant !== 3'b010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL grant_latency: got grant=%b busy=%b, expected 010/1", bus.src_grant, busy);
        end
        @(posedge aclk); #1;
        bus.src_req = '0;
        send_frame(1, 10, 8'h03, 0, 1'b1);
        checks++;
        if (mac_q.size() != 10) begin
            errors++;
            $display("FAIL single_beats: got %0d beats, expected 10", mac_q.size());
        end else begin
            for (int b = 0; b < 10; b++) begin
                exp = {beat_data(1, 0, b), (b == 9) ? 8'h03 : 8'hFF, b == 9, 1'b0};
                checks++;
                if (mac_q[b] !== exp) begin
                    errors++;
                    $display("FAIL single_beat%0d: got %h, expected %h", b, mac_q[b], exp);
                end
            end
        end
        checks++;
        if (frame_count !== 16'd1) begin
            errors++;
            $display("FAIL single_fc: got %0d, expected 1", frame_count);
        end
        // Re-request immediately: 2 gap cycles plus the arbitration cycle stay ungranted.
        bus.src_req = 3'b010;
        idle = 0;
        g = '0;
        while (g == '0 && idle < 20) begin
            @(negedge aclk);
            g = bus.src_grant;
            if (g == '0) idle++;
        end
        checks++;
        if (idle != 3 || g !== 3'b010) begin
            errors++;
            $display("FAIL ifg_gap: got %0d idle cycles grant=%b, expected 3 / 010", idle, g);
        end
        @(posedge aclk); #1;
        bus.src_req = '0;
        send_frame(1, 1, 8'h0F, 1, 1'b1);
    endtask

    task automatic test_round_robin();
        logic [2:0] g;
        logic [2:0] eg;
        beat_t exp;
        apply_reset();
        mac_q.delete();
        bus.src_req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            wait_grant(g);
            eg = 3'b001 << (k % 3);
            checks++;
            if (g !== eg) begin
                errors++;
                $display("FAIL rr_order%0d: got %b, expected %b", k, g, eg);
            end
            send_frame(k % 3, 3, 8'hFF, 10 + k, 1'b1);
        end
        bus.src_req = '0;
        checks++;
        if (mac_q.size() != 18) begin
            errors++;
            $display("FAIL rr_beats: got %0d beats, expected 18", mac_q.size());
        end else begin
            for (int i = 0; i < 18; i++) begin
                exp = {beat_data((i / 3) % 3, 10 + i / 3, i % 3), 8'hFF, (i % 3) == 2, 1'b0};
                checks++;
                if (mac_q[i] !== exp) begin
                    errors++;
                    $display("FAIL rr_beat%0d: got %h, expected %h", i, mac_q[i], exp);
                end
            end
        end
        checks++;
        if (frame_count !== 16'd6) begin
            errors++;
            $display("FAIL rr_fc: got %0d, expected 6", frame_count);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] g;
        logic [3:0] pat;
        bit acc;
        int b, c;
        beat_t exp;
        pat = 4'b1001;
        mac_q.delete();
        bus.src_req = 3'b001;
        wait_grant(g);
        checks++;
        if (g !== 3'b001) begin
            errors++;
            $display("FAIL bp_grant: got %b, expected 001", g);
        end
        bus.src_req = '0;
        b = 0;
        c = 0;
        while (b < 4 && c < 40) begin
            bus.m_axis_tready = pat[c % 4];
            bus.s_tdata[63:0] = beat_data(0, 20, b);
            bus.s_tkeep[7:0]  = 8'hFF;
            bus.s_tvalid[0]   = 1'b1;
            bus.s_tlast[0]    = (b == 3);
            @(negedge aclk);
            checks++;
            if (bus.src_tready !== {2'b00, pat[c % 4]}) begin
                errors++;
                $display("FAIL bp_mirror%0d: got %b, expected %b", c, bus.src_tready, {2'b00, pat[c % 4]});
            end
            acc = bus.src_tready[0];
            @(posedge aclk); #1;
            c++;
            if (acc) b++;
        end
        bus.s_tvalid[0] = 1'b0;
        bus.s_tlast[0]  = 1'b0;
        bus.m_axis_tready = 1'b1;
        checks++;
        if (b != 4 || c != 8) begin
            errors++;
            $display("FAIL bp_cycles: got %0d beats in %0d cycles, expected 4 in 8", b, c);
        end
        checks++;
        if (mac_q.size() != 4) begin
            errors++;
            $display("FAIL bp_beats: got %0d beats, expected 4", mac_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp = {beat_data(0, 20, i), 8'hFF, i == 3, 1'b0};
                checks++;
                if (mac_q[i] !== exp) begin
                    errors++;
                    $display("FAIL bp_beat%0d: got %h, expected %h", i, mac_q[i], exp);
                end
            end
        end
        checks++;
        if (tmo_pulses != 0 || frame_count !== 16'd7) begin
            errors++;
            $display("FAIL bp_status: got tmo=%0d fc=%0d, expected 0 / 7", tmo_pulses, frame_count);
        end
    endtask

    task automatic test_timeout();
        logic [2:0] g;
        int cyc;
        bit seen;
        beat_t exp;
        mac_q.delete();
        bus.src_req = 3'b100;
        wait_grant(g);
        checks++;
        if (g !== 3'b100) begin
            errors++;
            $display("FAIL tmo_grant: got %b, expected 100", g);
        end
        bus.src_req = 3'b001;
        send_frame(2, 2, 8'hFF, 30, 1'b0);
        // 64 stall cycles follow the last accepted edge; the pulse shows on the 65th negedge.
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge aclk);
            cyc++;
            seen = timeout_err;
        end
        checks++;
        if (!seen || cyc != 65) begin
            errors++;
            $display("FAIL tmo_latency: got seen=%b after %0d negedges, expected 1 after 65", seen, cyc);
        end
        checks++;
        if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tkeep, bus.m_axis_tdata}
            !== {3'b111, 8'h01, 64'h0}) begin
            errors++;
            $display("FAIL abort_beat: got v=%b l=%b u=%b k=%h d=%h, expected 1/1/1/01/0", bus.m_axis_tvalid,
                     bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tkeep, bus.m_axis_tdata);
        end
        checks++;
        if (bus.src_grant !== 3'b000 || bus.src_tready !== 3'b000 || abort_count !== 8'd1) begin
            errors++;
            $display("FAIL abort_state: got grant=%b tready=%b ac=%0d, expected 000/000/1",
                     bus.src_grant, bus.src_tready, abort_count);
        end
        @(posedge aclk); #1;
        @(negedge aclk);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_pulse_width: got %b, expected 0", timeout_err);
        end
        @(posedge aclk); #1;
        wait_grant(g);
        checks++;
        if (g !== 3'b001) begin
            errors++;
            $display("FAIL tmo_next_grant: got %b, expected 001", g);
        end
        bus.src_req = '0;
        send_frame(0, 1, 8'hFF, 31, 1'b1);
        checks++;
        if (mac_q.size() != 4) begin
            errors++;
            $display("FAIL tmo_beats: got %0d beats, expected 4", mac_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i < 2)       exp = {beat_data(2, 30, i), 8'hFF, 1'b0, 1'b0};
                else if (i == 2) exp = {64'h0, 8'h01, 1'b1, 1'b1};
                else             exp = {beat_data(0, 31, 0), 8'hFF, 1'b1, 1'b0};
                checks++;
                if (mac_q[i] !== exp) begin
                    errors++;
                    $display("FAIL tmo_beat%0d: got %h, expected %h", i, mac_q[i], exp);
                end
            end
        end
        checks++;
        if (tmo_pulses != 1 || frame_count !== 16'd8) begin
            errors++;
            $display("FAIL tmo_status: got pulses=%0d fc=%0d, expected 1 / 8", tmo_pulses, frame_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [2:0] g;
        bus.src_req = 3'b010;
        wait_grant(g);
        checks++;
        if (g !== 3'b010) begin
            errors++;
            $display("FAIL mid_grant: got %b, expected 010", g);
        end
        bus.src_req = '0;
        send_frame(1, 4, 8'hFF, 40, 1'b0);
        bus.s_tdata[127:64] = beat_data(1, 40, 4);
        bus.s_tvalid[1] = 1'b1;
        areset = 1'b1;
        @(negedge aclk);
        @(posedge aclk); #1;
        areset = 1'b0;
        bus.s_tvalid[1] = 1'b0;
        bus.src_req = 3'b101;
        @(negedge aclk);
        checks++;
        if ({bus.src_grant, bus.src_tready, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser,
             bus.m_axis_tkeep, bus.m_axis_tdata} !== 81'd0) begin
            errors++;
            $display("FAIL mid_outputs: got grant=%b tready=%b v=%b d=%h, expected all 0",
                     bus.src_grant, bus.src_tready, bus.m_axis_tvalid, bus.m_axis_tdata);
        end
        checks++;
        if ({busy, timeout_err, frame_count, abort_count} !== 26'd0) begin
            errors++;
            $display("FAIL mid_status: got busy=%b tmo=%b fc=%0d ac=%0d, expected 0/0/0/0",
                     busy, timeout_err, frame_count, abort_count);
        end
        @(posedge aclk); #1;
        wait_grant(g);
        checks++;
        if (g !== 3'b001) begin
            errors++;
            $display("FAIL mid_first_grant: got %b, expected 001", g);
        end
        bus.src_req = 3'b100;
        send_frame(0, 1, 8'hFF, 41, 1'b1);
        wait_grant(g);
        checks++;
        if (g !== 3'b100) begin
            errors++;
            $display("FAIL mid_second_grant: got %b, expected 100", g);
        end
        bus.src_req = '0;
        send_frame(2, 1, 8'hFF, 42, 1'b1);
        checks++;
        if (frame_count !== 16'd2) begin
            errors++;
            $display("FAIL mid_fc: got %0d, expected 2", frame_count);
        end
    endtask

    task automatic test_no_gap();
        int n;
        logic eg;
        bus0.src_req = 3'b001;
        bus0.s_tvalid = 3'b001;
        bus0.s_tlast = 3'b001;
        n = 0;
        while (bus0.src_grant[0] !== 1'b1 && n < 20) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (bus0.src_grant !== 3'b001) begin
            errors++;
            $display("FAIL nogap_grant: got %b, expected 001", bus0.src_grant);
        end
        for (int i = 1; i < 8; i++) begin
            @(negedge aclk);
            eg = (i % 2 == 0);
            checks++;
            if (bus0.src_grant[0] !== eg) begin
                errors++;
                $display("FAIL nogap_pattern%0d: got %b, expected %b", i, bus0.src_grant[0], eg);
            end
        end
        checks++;
        if (frame_count0 !== 16'd4) begin
            errors++;
            $display("FAIL nogap_fc: got %0d, expected 4", frame_count0);
        end
        @(posedge aclk); #1;
        bus0.src_req = '0;
        repeat (2) @(posedge aclk);
        #1 bus0.s_tvalid = '0;
        bus0.s_tlast = '0;
        repeat (2) @(posedge aclk);
    endtask

    initial begin
        bus0.src_req = '0; bus0.s_tvalid = '0; bus0.s_tlast = '0;
        bus0.s_tkeep = {3{8'hFF}};
        bus0.s_tdata = {3{64'h0123_4567_89AB_CDEF}};
        bus0.m_axis_tready = 1'b1;
        apply_reset();
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid_frame();
        test_no_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
